// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU block: op codes, datapath width and
// the combinational ALU function used by the arbiter top.
package alu_pkg;

    localparam int ALU_W   = 32;
    localparam int ALU_SHW = $clog2(ALU_W);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef struct packed {
        logic [ALU_W-1:0] res;
        logic             err;
    } alu_result_t;

    // Shift amounts of ALU_W or more flush the operand to zero rather than wrapping.
    function automatic alu_result_t alu_exec(input logic [3:0]       op,
                                             input logic [ALU_W-1:0] a,
                                             input logic [ALU_W-1:0] b);
        alu_result_t r;
        logic        big_shift;
        r.res     = '0;
        r.err     = 1'b0;
        big_shift = |b[ALU_W-1:ALU_SHW];
        case (op)
            ALU_AND:   r.res = a & b;
            ALU_OR:    r.res = a | b;
            ALU_ADD:   r.res = a + b;
            ALU_SUB:   r.res = a - b;
            ALU_SLL:   r.res = big_shift ? '0 : (a << b[ALU_SHW-1:0]);
            ALU_SRL:   r.res = big_shift ? '0 : (a >> b[ALU_SHW-1:0]);
            ALU_PASSB: r.res = b;
            default:   r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (modulo N)
// when enabled, as both a one-hot vector and a binary index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    // Rank each requester by its distance above ptr and keep the closest one.
    always_comb begin
        int best_d;
        int d;
        best_d    = N;
        d         = 0;
        grant_idx = '0;
        grant     = '0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - int'(ptr)) % N;
            if (req[i] && (d < best_d)) begin
                best_d    = d;
                grant_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = en && (best_d < N) && (grant_idx == IW'(i));
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One 32-bit ALU shared round-robin by NREQ requesters, with a single
// registered id-tagged response slot that can drain and refill every cycle.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [ALU_W*NREQ-1:0] req_a,
    input  logic [ALU_W*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [ALU_W-1:0]      rsp_res,
    output logic                  rsp_zero,
    output logic                  rsp_err
);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant;
    logic             slot_free;
    logic             xfer;
    logic [3:0]       sel_op;
    logic [ALU_W-1:0] sel_a;
    logic [ALU_W-1:0] sel_b;
    alu_result_t      alu_out;

    // Only data-independent terms feed the arbiter, so no path from operands to req_ready.
    assign slot_free = rst_n && (!rsp_valid || rsp_ready);

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    assign sel_op  = req_op[32'(grant_idx)*4 +: 4];
    assign sel_a   = req_a[32'(grant_idx)*ALU_W +: ALU_W];
    assign sel_b   = req_b[32'(grant_idx)*ALU_W +: ALU_W];
    assign alu_out = alu_exec(sel_op, sel_a, sel_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_idx;
            rsp_res   <= alu_out.res;
            rsp_zero  <= (alu_out.res == '0);
            rsp_err   <= alu_out.err;
            rr_ptr    <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
